// File: rtl/fc_layer_engine_pkg.sv
// Shared types, default widths and the saturating rescale helper for the
// fully-connected layer engine.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } fc_state_t;

  localparam int DEF_IN_DIM  = 64;
  localparam int DEF_OUT_DIM = 32;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_FRAC_W  = 8;
  localparam int DEF_ACC_W   = 40;

  // Working width of the helper; callers sign-extend their accumulator to it.
  localparam int SAT_W = 64;

  // Arithmetic right shift by frac_w (floor) then clamp to a signed data_w range.
  // The result fits in data_w bits; callers narrow it with a size cast.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      data_w,
    input int                      frac_w
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi)      return hi;
    else if (sh < lo) return lo;
    else              return sh;
  endfunction

endpackage

// File: rtl/fc_layer_engine_mac_unit.sv
// Multiply-accumulate datapath: one signed product per cycle into a wide
// accumulator that can be preloaded with the bias aligned to the product scale.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     i_load_bias,
  input  logic                     i_accumulate,
  input  logic signed [DATA_W-1:0] i_b_data,
  input  logic signed [DATA_W-1:0] i_in_data,
  input  logic signed [DATA_W-1:0] i_w_data,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [ACC_W-1:0]    r_acc;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_bias_ext;

  assign w_prod     = i_in_data * i_w_data;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  // Bias shares the operand Q format, so shift it up to the product's 2*FRAC_W scale.
  assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_W){i_b_data[DATA_W-1]}}, i_b_data, {FRAC_W{1'b0}}};
  assign o_acc      = r_acc;

  // Accumulator: bias preload, product accumulate, otherwise hold.
  always_ff @(posedge clk) begin
    if (i_load_bias)       r_acc <= w_bias_ext;
    else if (i_accumulate) r_acc <= r_acc + w_prod_ext;
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: on a start pulse, walks every output neuron,
// streams bias/inputs/weights from synchronous memories, and writes the
// saturated result of each neuron to the output buffer, then pulses out_done.
// Build option: define FC_RELU_EN to clamp negative results to zero on write.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter  int IN_DIM  = DEF_IN_DIM,
  parameter  int OUT_DIM = DEF_OUT_DIM,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int FRAC_W  = DEF_FRAC_W,
  parameter  int ACC_W   = DEF_ACC_W,
  localparam int IA_W    = $clog2(IN_DIM),
  localparam int WA_W    = $clog2(IN_DIM*OUT_DIM),
  localparam int OA_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     out_done,
  output logic [IA_W-1:0]          in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [WA_W-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [OA_W-1:0]          b_addr,
  input  logic signed [DATA_W-1:0] b_data,
  output logic                     out_we,
  output logic [OA_W-1:0]          out_addr,
  output logic signed [DATA_W-1:0] out_data
);

  fc_state_t               r_state;
  fc_state_t               w_next;
  logic [OA_W-1:0]         r_o;
  logic [IA_W-1:0]         r_i;
  logic [WA_W-1:0]         r_w;
  logic                    w_last_i;
  logic                    w_last_o;
  logic                    w_load;
  logic                    w_accum;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [SAT_W-1:0] w_acc_ext;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] w_result;

  assign w_last_i = (r_i == IA_W'(IN_DIM - 1));
  assign w_last_o = (r_o == OA_W'(OUT_DIM - 1));

  // The first MAC cycle sees the bias fetched in BIAS; later MAC cycles and
  // DRAIN see the product for the address issued one cycle earlier.
  assign w_load  = (r_state == MAC) && (r_i == '0);
  assign w_accum = ((r_state == MAC) && (r_i != '0)) || (r_state == DRAIN);

  fc_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk          (clk),
    .i_load_bias  (w_load),
    .i_accumulate (w_accum),
    .i_b_data     (b_data),
    .i_in_data    (in_data),
    .i_w_data     (w_data),
    .o_acc        (w_acc)
  );

  assign w_acc_ext = {{(SAT_W-ACC_W){w_acc[ACC_W-1]}}, w_acc};
  assign w_sat     = DATA_W'(sat_shift(w_acc_ext, DATA_W, FRAC_W));
`ifdef FC_RELU_EN
  assign w_result  = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign w_result  = w_sat;
`endif

  // Addresses are the counters themselves; they hold outside BIAS/MAC.
  assign in_addr  = r_i;
  assign w_addr   = r_w;
  assign b_addr   = r_o;
  assign out_addr = r_o;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = BIAS;
      BIAS:    w_next = MAC;
      MAC:     if (w_last_i) w_next = DRAIN;
      DRAIN:   w_next = WRITE;
      WRITE:   w_next = w_last_o ? DONE : BIAS;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Neuron, input and weight counters; the weight address runs linearly
  // through the row-major ROM across the whole layer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_o <= '0;
      r_i <= '0;
      r_w <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_o <= '0;
          r_i <= '0;
          r_w <= '0;
        end
        MAC: begin
          r_i <= w_last_i ? '0 : r_i + IA_W'(1);
          r_w <= r_w + WA_W'(1);
        end
        WRITE: if (!w_last_o) r_o <= r_o + OA_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state; write data is zero except on a write.
  always_comb begin
    busy     = (r_state != IDLE);
    out_done = (r_state == DONE);
    out_we   = (r_state == WRITE);
    out_data = '0;
    if (r_state == WRITE) out_data = w_result;
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: a small instance (4 inputs, 2 neurons) driven
// from a table of hand-computed vectors and a default-size instance checked
// against a behavioural fixed-point model.
module tb_fc_layer_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  // Small instance signals
  logic               s_start = 1'b0;
  logic               s_busy, s_out_done, s_out_we;
  logic [1:0]         s_in_addr;
  logic [2:0]         s_w_addr;
  logic [0:0]         s_b_addr, s_out_addr;
  logic signed [15:0] s_in_data, s_w_data, s_b_data, s_out_data;
  logic signed [15:0] s_in_mem [4];
  logic signed [15:0] s_w_mem  [8];
  logic signed [15:0] s_b_mem  [2];

  // Default instance signals
  logic               d_start = 1'b0;
  logic               d_busy, d_out_done, d_out_we;
  logic [5:0]         d_in_addr;
  logic [10:0]        d_w_addr;
  logic [4:0]         d_b_addr, d_out_addr;
  logic signed [15:0] d_in_data, d_w_data, d_b_data, d_out_data;
  logic signed [15:0] d_in_mem [64];
  logic signed [15:0] d_w_mem  [2048];
  logic signed [15:0] d_b_mem  [32];

  fc_layer_engine #(.IN_DIM(4), .OUT_DIM(2), .DATA_W(16), .FRAC_W(8), .ACC_W(40)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .out_done(s_out_done),
    .in_addr(s_in_addr), .in_data(s_in_data), .w_addr(s_w_addr), .w_data(s_w_data),
    .b_addr(s_b_addr), .b_data(s_b_data), .out_we(s_out_we), .out_addr(s_out_addr),
    .out_data(s_out_data)
  );

  fc_layer_engine #(.IN_DIM(64), .OUT_DIM(32), .DATA_W(16), .FRAC_W(8), .ACC_W(40)) dut_d (
    .clk(clk), .rst(rst), .start(d_start), .busy(d_busy), .out_done(d_out_done),
    .in_addr(d_in_addr), .in_data(d_in_data), .w_addr(d_w_addr), .w_data(d_w_data),
    .b_addr(d_b_addr), .b_data(d_b_data), .out_we(d_out_we), .out_addr(d_out_addr),
    .out_data(d_out_data)
  );

  // Synchronous-read memory models (data one cycle after address)
  always @(posedge clk) begin
    s_in_data <= s_in_mem[s_in_addr];
    s_w_data  <= s_w_mem[s_w_addr];
    s_b_data  <= s_b_mem[s_b_addr];
    d_in_data <= d_in_mem[d_in_addr];
    d_w_data  <= d_w_mem[d_w_addr];
    d_b_data  <= d_b_mem[d_b_addr];
  end

  // Output-buffer write logs and done counters
  int                 s_done_n = 0;
  int                 d_done_n = 0;
  int                 s_log_a[$];
  logic signed [15:0] s_log_d[$];
  int                 d_log_a[$];
  logic signed [15:0] d_log_d[$];

  always @(posedge clk) begin
    if (s_out_we) begin
      s_log_a.push_back(int'(s_out_addr));
      s_log_d.push_back(s_out_data);
    end
    if (d_out_we) begin
      d_log_a.push_back(int'(d_out_addr));
      d_log_d.push_back(d_out_data);
    end
    if (s_out_done) s_done_n <= s_done_n + 1;
    if (d_out_done) d_done_n <= d_done_n + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][15:0] in;
    logic [7:0][15:0] w;
    logic [1:0][15:0] b;
    logic [1:0][15:0] exp;
  } vec_t;

  vec_t vecs [5];

  // One run of the small instance: start pulse, then a fixed 40-cycle window
  // with optional extra start pulses in cycles p1/p2.
  task automatic run_s(input int p1, input int p2, output int dcyc, output int busy1,
                       output int busy_after, output int baddr8, output int waddr9);
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    dcyc = 0; busy1 = -1; busy_after = -1; baddr8 = -1; waddr9 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 1) busy1 = int'(s_busy);
      if (c == 8) baddr8 = int'(s_b_addr);
      if (c == 9) waddr9 = int'(s_w_addr);
      if (dcyc != 0 && c == dcyc + 1) busy_after = int'(s_busy);
      if (s_out_done && dcyc == 0) dcyc = c;
      s_start = (c == p1 || c == p2);
      @(negedge clk);
    end
    s_start = 1'b0;
  endtask

  task automatic load_s(input vec_t v);
    for (int k = 0; k < 4; k++) s_in_mem[k] = $signed(v.in[k]);
    for (int k = 0; k < 8; k++) s_w_mem[k]  = $signed(v.w[k]);
    for (int k = 0; k < 2; k++) s_b_mem[k]  = $signed(v.b[k]);
  endtask

  // Check the two writes logged since index la against the expected vector.
  task automatic chk_writes_s(input string nm, input int la, input int dn, input vec_t v);
    chk({nm, " done_count"}, longint'(s_done_n - dn), 1);
    chk({nm, " write_count"}, longint'(s_log_a.size() - la), 2);
    for (int k = 0; k < 2; k++) begin
      if (la + k < s_log_a.size()) begin
        chk($sformatf("%s addr[%0d]", nm, k), longint'(s_log_a[la+k]), longint'(k));
        chk($sformatf("%s data[%0d]", nm, k), longint'(s_log_d[la+k]), longint'($signed(v.exp[k])));
      end
    end
  endtask

  function automatic longint model_d(input int o);
    longint acc;
    acc = longint'(d_b_mem[o]) <<< 8;
    for (int i = 0; i < 64; i++) acc += longint'(d_in_mem[i]) * longint'(d_w_mem[o*64+i]);
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
`ifdef FC_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  initial begin
    int dcyc, busy1, busy_after, baddr8, waddr9, la, dn, dla, ddn;

    // Directed vectors (element [0] is the rightmost in each concatenation)
    vecs[0].in = {4{16'd256}};  vecs[0].w = {8{16'd128}};   vecs[0].b = {2{16'd64}};
    vecs[0].exp = {2{16'd576}};
    vecs[1].in = {4{16'h7FFF}}; vecs[1].w = {8{16'h7FFF}};  vecs[1].b = {2{16'h7FFF}};
    vecs[1].exp = {2{16'h7FFF}};
    vecs[2].in = {4{16'h7FFF}}; vecs[2].w = {8{16'h8000}};  vecs[2].b = {2{16'h7FFF}};
    vecs[2].exp = {2{16'h8000}};
    vecs[3].in = {4{16'd256}};  vecs[3].w = {8{16'hFF80}};  vecs[3].b = {2{16'd64}};
`ifdef FC_RELU_EN
    vecs[3].exp = {2{16'd0}};
`else
    vecs[3].exp = {2{16'hFE40}};
`endif
    vecs[4].in = {16'd0, 16'hFF00, 16'd512, 16'd256};
    vecs[4].w = {{4{16'd0}}, {4{16'd256}}};
    vecs[4].b = {16'd256, 16'd0};
    vecs[4].exp = {16'd256, 16'd512};

    for (int i = 0; i < 64; i++) d_in_mem[i] = 16'((i * 37) % 512 - 256);
    for (int o = 0; o < 32; o++) begin
      d_b_mem[o] = 16'(o * 100 - 1600);
      for (int i = 0; i < 64; i++) d_w_mem[o*64+i] = 16'((o * 13 + i * 7) % 256 - 128);
    end
    load_s(vecs[0]);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset s_busy", longint'(s_busy), 0);
    chk("reset s_out_done", longint'(s_out_done), 0);
    chk("reset s_out_we", longint'(s_out_we), 0);
    chk("reset s_out_data", longint'(s_out_data), 0);
    chk("reset d_busy", longint'(d_busy), 0);
    chk("reset d_w_addr", longint'(d_w_addr), 0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      load_s(vecs[v]);
      la = s_log_a.size();
      dn = s_done_n;
      run_s(0, 0, dcyc, busy1, busy_after, baddr8, waddr9);
      chk($sformatf("vec%0d done_cycle", v), longint'(dcyc), 15);
      chk($sformatf("vec%0d busy_cycle1", v), longint'(busy1), 1);
      chk($sformatf("vec%0d busy_after_done", v), longint'(busy_after), 0);
      if (v == 0) begin
        chk("vec0 b_addr_neuron1_bias", longint'(baddr8), 1);
        chk("vec0 w_addr_neuron1_mac0", longint'(waddr9), 4);
      end
      chk_writes_s($sformatf("vec%0d", v), la, dn, vecs[v]);
    end

    // start pulsed during MAC and during DONE: ignored, no queued run
    load_s(vecs[0]);
    la = s_log_a.size();
    dn = s_done_n;
    run_s(3, 15, dcyc, busy1, busy_after, baddr8, waddr9);
    chk("restart_ignored done_cycle", longint'(dcyc), 15);
    chk("restart_ignored busy_after_done", longint'(busy_after), 0);
    chk_writes_s("restart_ignored", la, dn, vecs[0]);

    // A fresh start after out_done repeats the full run
    load_s(vecs[4]);
    la = s_log_a.size();
    dn = s_done_n;
    run_s(0, 0, dcyc, busy1, busy_after, baddr8, waddr9);
    chk("repeat done_cycle", longint'(dcyc), 15);
    chk_writes_s("repeat", la, dn, vecs[4]);

    // start coincident with reset: reset wins
    @(negedge clk);
    rst = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    chk("start_with_reset s_busy", longint'(s_busy), 0);
    rst = 1'b1;
    s_start = 1'b0;
    @(negedge clk);
    chk("start_with_reset s_busy_later", longint'(s_busy), 0);

    // Reset asserted in cycle 6 of a run on both instances
    la = s_log_a.size();  dn = s_done_n;
    dla = d_log_a.size(); ddn = d_done_n;
    s_start = 1'b1; d_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; d_start = 1'b0;
    for (int c = 1; c < 6; c++) @(negedge clk);
    chk("pre_abort d_busy", longint'(d_busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort s_busy", longint'(s_busy), 0);
    chk("abort s_out_we", longint'(s_out_we), 0);
    chk("abort s_out_data", longint'(s_out_data), 0);
    chk("abort s_in_addr", longint'(s_in_addr), 0);
    chk("abort d_busy", longint'(d_busy), 0);
    chk("abort d_out_done", longint'(d_out_done), 0);
    chk("abort d_in_addr", longint'(d_in_addr), 0);
    chk("abort d_w_addr", longint'(d_w_addr), 0);
    chk("abort d_b_addr", longint'(d_b_addr), 0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort s_no_done", longint'(s_done_n - dn), 0);
    chk("abort s_no_writes", longint'(s_log_a.size() - la), 0);
    chk("abort d_no_done", longint'(d_done_n - ddn), 0);
    chk("abort d_no_writes", longint'(d_log_a.size() - dla), 0);

    // Fresh full run at default dimensions
    dla = d_log_a.size(); ddn = d_done_n;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    dcyc = 0;
    for (int c = 1; c <= 2300; c++) begin
      if (d_out_done && dcyc == 0) dcyc = c;
      if (dcyc != 0 && c > dcyc + 2) break;
      @(negedge clk);
    end
    chk("default done_cycle", longint'(dcyc), 2145);
    chk("default done_count", longint'(d_done_n - ddn), 1);
    chk("default write_count", longint'(d_log_a.size() - dla), 32);
    for (int o = 0; o < 32; o++) begin
      if (dla + o < d_log_a.size()) begin
        chk($sformatf("default addr[%0d]", o), longint'(d_log_a[dla+o]), longint'(o));
        chk($sformatf("default data[%0d]", o), longint'(d_log_d[dla+o]), model_d(o));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
